seq_detect_sched: RTL and testbench

- Scheduler that shares one programmable serial pattern detector among NREQ bit-stream requesters.
- Round-robin arbitration grants one requester per frame.
- While granted, that requester's bits are gated into the internal detector under a valid/ready handshake.
- At frame end the block reports the overlapping-match count and the requester id. It sits between the serial-input sources and the status/result logic.

---
 rtl/seq_detect_sched_if.sv | 32 +++
 rtl/seq_detect_sched.sv | 156 +++++++++++++++
 tb/tb_seq_detect_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_sched_if.sv
// Bus bundle between the bit-stream requesters / status logic and the
// shared pattern-detector scheduler.
interface seq_detect_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PAT_W = 4,
  parameter int unsigned LEN_W = 8
);
  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  bit_in;
  logic [NREQ-1:0]  bit_vld;
  logic [NREQ-1:0]  bit_rdy;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic             done;
  logic [ID_W-1:0]  done_id;
  logic [LEN_W-1:0] match_cnt;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, req, bit_in, bit_vld,
    input  bit_rdy, gnt, busy, done, done_id, match_cnt
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, req, bit_in, bit_vld,
    output bit_rdy, gnt, busy, done, done_id, match_cnt
  );
endinterface

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one overlapping serial pattern detector
// among NREQ requesters; one frame per grant, result reported at frame end.
module seq_detect_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PAT_W = 4,
  parameter int unsigned LEN_W = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_sched_if.slave bus
);
  localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned FILL_W = $clog2(PAT_W);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, owner, winner;
  logic             any_req;
  logic [NREQ-1:0]  win_oh;
  logic [PAT_W-1:0] pat_sh, pat_act, window;
  logic [LEN_W-1:0] len_sh, len_act, bit_cnt, mcnt, mcnt_nxt;
  logic [PAT_W-2:0] shift;
  logic [FILL_W-1:0] fill;
  logic             bit_sel, vld_sel, accept, hit, last_bit;
  logic [NREQ-1:0]  gnt_q, rdy_q, gnt_nxt, rdy_nxt;
  logic             busy_q, done_q, busy_nxt, done_nxt;
  logic [ID_W-1:0]  done_id_q;
  logic [LEN_W-1:0] match_q;

  // Round-robin pick: first set req at or after rr_ptr, wrapping
  always_comb begin
    int unsigned idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = 32'(rr_ptr) + 32'(i);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && bus.req[ID_W'(idx)]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

  assign win_oh = NREQ'(1) << winner;

  // Detector datapath on the granted lane
  assign bit_sel  = bus.bit_in[owner];
  assign vld_sel  = bus.bit_vld[owner];
  assign accept   = (state == RUN) && rdy_q[owner] && vld_sel;
  assign window   = {shift, bit_sel};
  assign hit      = accept && (fill >= FILL_W'(PAT_W - 1)) && (window == pat_act);
  assign mcnt_nxt = (hit && (mcnt != '1)) ? mcnt + LEN_W'(1) : mcnt;
  assign last_bit = accept && ((bit_cnt + LEN_W'(1)) == len_act);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = RUN;
      RUN:     if ((len_act == '0) || last_bit) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    gnt_nxt  = gnt_q;
    rdy_nxt  = rdy_q;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == REPORT);
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nxt = win_oh;
          rdy_nxt = (len_sh != '0) ? win_oh : '0;
        end
      end
      RUN: begin
        if (state_nxt == REPORT) begin
          gnt_nxt = '0;
          rdy_nxt = '0;
        end
      end
      default: begin
        gnt_nxt = '0;
        rdy_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      rdy_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      match_q   <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      pat_sh    <= '0;
      len_sh    <= '0;
      pat_act   <= '0;
      len_act   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      fill      <= '0;
      mcnt      <= '0;
    end else begin
      gnt_q  <= gnt_nxt;
      rdy_q  <= rdy_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (bus.cfg_we) begin
        pat_sh <= bus.cfg_pattern;
        len_sh <= bus.cfg_len;
      end
      // Shadow config becomes active only at grant
      if ((state == IDLE) && any_req) begin
        owner   <= winner;
        rr_ptr  <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
        pat_act <= pat_sh;
        len_act <= len_sh;
        bit_cnt <= '0;
        shift   <= '0;
        fill    <= '0;
        mcnt    <= '0;
      end else if (accept) begin
        shift   <= window[PAT_W-2:0];
        fill    <= (fill == FILL_W'(PAT_W - 1)) ? fill : fill + FILL_W'(1);
        bit_cnt <= bit_cnt + LEN_W'(1);
        mcnt    <= mcnt_nxt;
      end
      if ((state == RUN) && (state_nxt == REPORT)) begin
        done_id_q <= owner;
        match_q   <= mcnt_nxt;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bit_rdy   = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: overlap counting, round-robin order,
// handshake stalls, config shadowing, zero-length frames and mid-frame reset.
module tb_seq_detect_sched;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  seq_detect_sched_if #(.NREQ(4), .PAT_W(4), .LEN_W(8)) bus ();

  seq_detect_sched #(.NREQ(4), .PAT_W(4), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] pat, input logic [7:0] len);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    step();
    bus.cfg_we      = 1'b0;
  endtask

  // Step until some grant appears, bounded
  task automatic wait_gnt(input int budget);
    int k;
    k = 0;
    step();
    while ((bus.gnt == '0) && (k < budget)) begin
      step();
      k++;
    end
    check("gnt_seen", 32'(bus.gnt != '0), 32'(1));
  endtask

  // Drive n cycles on one lane (MSB-first literals); other lanes carry inverted junk
  task automatic stream(input int lane, input logic [15:0] bits, input logic [15:0] vld, input int n);
    for (int i = 0; i < n; i++) begin
      check("bit_rdy", 32'(bus.bit_rdy), 32'(1) << lane);
      bus.bit_in        = bits[n-1-i] ? 4'b0000 : 4'b1111;
      bus.bit_in[lane]  = bits[n-1-i];
      bus.bit_vld       = 4'b1111;
      bus.bit_vld[lane] = vld[n-1-i];
      step();
    end
    bus.bit_vld = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len = '0;
    bus.req = '0;
    bus.bit_in = '0;
    bus.bit_vld = '0;
    step();
    step();
    check("rst_gnt", 32'(bus.gnt), 32'(0));
    check("rst_rdy", 32'(bus.bit_rdy), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_id", 32'(bus.done_id), 32'(0));
    check("rst_cnt", 32'(bus.match_cnt), 32'(0));
    rst = 1'b0;

    // Overlapping matches of 1011 in 1011011
    cfg(4'b1011, 8'd7);
    bus.req = 4'b0001;
    wait_gnt(8);
    check("t1_gnt", 32'(bus.gnt), 32'(4'b0001));
    check("t1_busy", 32'(bus.busy), 32'(1));
    bus.req = '0;
    stream(0, 16'b1011011, 16'h7f, 7);
    check("t1_done", 32'(bus.done), 32'(1));
    check("t1_id", 32'(bus.done_id), 32'(0));
    check("t1_cnt", 32'(bus.match_cnt), 32'(2));
    check("t1_gnt_rep", 32'(bus.gnt), 32'(0));
    check("t1_busy_rep", 32'(bus.busy), 32'(1));
    step();
    check("t1_done_low", 32'(bus.done), 32'(0));
    check("t1_idle", 32'(bus.busy), 32'(0));
    check("t1_cnt_hold", 32'(bus.match_cnt), 32'(2));

    // Round robin between lanes 1 and 3
    cfg(4'b1011, 8'd2);
    bus.req = 4'b1010;
    for (int f = 0; f < 4; f++) begin
      int lane;
      lane = (f % 2 == 0) ? 1 : 3;
      wait_gnt(8);
      check("rr_gnt", 32'(bus.gnt), 32'(1) << lane);
      stream(lane, 16'b00, 16'b11, 2);
      check("rr_done", 32'(bus.done), 32'(1));
      check("rr_id", 32'(bus.done_id), 32'(lane));
    end
    bus.req = '0;

    // Stalled handshake on lane 2: only 4 of 7 cycles carry valid bits
    cfg(4'b1011, 8'd4);
    bus.req = 4'b0100;
    wait_gnt(8);
    check("t3_gnt", 32'(bus.gnt), 32'(4'b0100));
    bus.req = '0;
    stream(2, 16'b1110111, 16'b1001101, 7);
    check("t3_done", 32'(bus.done), 32'(1));
    check("t3_id", 32'(bus.done_id), 32'(2));
    check("t3_cnt", 32'(bus.match_cnt), 32'(1));

    // Zero-length frame: one RUN cycle, no bit_rdy, count 0
    cfg(4'b1011, 8'd0);
    bus.req = 4'b0001;
    bus.bit_vld = 4'b0001;
    wait_gnt(8);
    check("t5_gnt", 32'(bus.gnt), 32'(4'b0001));
    check("t5_rdy", 32'(bus.bit_rdy), 32'(0));
    bus.req = '0;
    step();
    bus.bit_vld = '0;
    check("t5_done", 32'(bus.done), 32'(1));
    check("t5_cnt", 32'(bus.match_cnt), 32'(0));
    check("t5_id", 32'(bus.done_id), 32'(0));
    check("t5_gnt_off", 32'(bus.gnt), 32'(0));

    // Config written mid-frame only affects the following frame
    cfg(4'b1011, 8'd7);
    bus.req = 4'b0010;
    wait_gnt(8);
    check("t4_gnt", 32'(bus.gnt), 32'(4'b0010));
    bus.cfg_we = 1'b1;
    bus.cfg_pattern = 4'b0000;
    bus.cfg_len = 8'd6;
    stream(1, 16'b1011011, 16'h7f, 7);
    bus.cfg_we = 1'b0;
    check("t4_done", 32'(bus.done), 32'(1));
    check("t4_cnt", 32'(bus.match_cnt), 32'(2));
    wait_gnt(8);
    check("t4_gnt2", 32'(bus.gnt), 32'(4'b0010));
    stream(1, 16'b000000, 16'h3f, 6);
    check("t4_done2", 32'(bus.done), 32'(1));
    check("t4_id2", 32'(bus.done_id), 32'(1));
    check("t4_cnt2", 32'(bus.match_cnt), 32'(3));
    bus.req = '0;

    // Reset after 3 of 7 bits abandons the frame
    cfg(4'b1011, 8'd7);
    bus.req = 4'b0100;
    wait_gnt(8);
    check("t6_gnt", 32'(bus.gnt), 32'(4'b0100));
    stream(2, 16'b101, 16'b111, 3);
    rst = 1'b1;
    step();
    check("t6_gnt_rst", 32'(bus.gnt), 32'(0));
    check("t6_busy_rst", 32'(bus.busy), 32'(0));
    check("t6_done_rst", 32'(bus.done), 32'(0));
    check("t6_rdy_rst", 32'(bus.bit_rdy), 32'(0));
    check("t6_id_rst", 32'(bus.done_id), 32'(0));
    check("t6_cnt_rst", 32'(bus.match_cnt), 32'(0));
    rst = 1'b0;
    bus.req = 4'b1010;
    step();
    check("t6_regrant", 32'(bus.gnt), 32'(4'b0010));
    check("t6_no_done", 32'(bus.done), 32'(0));
    bus.req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
